hd_controlador_dma: RTL and testbench

Block-transfer engine sitting directly upstream of the simulated HD. It drives the HD's trilha/setor address, write-select and write data.
- Copies a run of consecutive 32-bit words in either direction: HD to main memory (program load) or main memory to HD (save).
- Sector addressing is linear: setor wraps into the next trilha.
- Both the HD and main memory have registered reads with 1-cycle latency. The integration ties HD read_clock and write_clock to clock.

---
 rtl/hd_pkg.sv | 26 ++
 rtl/hd_contador_endereco.sv | 44 ++++
 rtl/hd_controlador_dma.sv | 146 ++++++++++++++
 tb/tb_hd_controlador_dma.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_pkg.sv
// ============================================================================
// Package : hd_pkg
// Shared HD geometry defaults, controller state encoding and direction codes.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package hd_pkg;

    localparam int BITS_TRILHA = 4;
    localparam int BITS_SETOR  = 6;
    localparam int NUM_SETORES = 2 ** BITS_SETOR;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        ESCRITA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic DIR_HD_PARA_MEM = 1'b0;
    localparam logic DIR_MEM_PARA_HD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/hd_contador_endereco.sv
// ============================================================================
// Module : hd_contador_endereco
// Linear track/sector address register: sector carries into track, and the
//          register holds at the last sector of the last track.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hd_contador_endereco #(
    parameter int BITS_TRILHA = 4,
    parameter int BITS_SETOR  = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carrega,
    input  logic                   incrementa,
    input  logic [BITS_TRILHA-1:0] trilha_carga,
    input  logic [BITS_SETOR-1:0]  setor_carga,
    output logic [BITS_TRILHA-1:0] trilha,
    output logic [BITS_SETOR-1:0]  setor,
    output logic                   ultimo
);

    localparam int c_LARGURA = BITS_TRILHA + BITS_SETOR;

    logic [c_LARGURA-1:0] r_endereco;

    // Track and sector concatenated so a plain increment gives the sector carry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_endereco <= '0;
        end else if (carrega) begin
            r_endereco <= {trilha_carga, setor_carga};
        end else if (incrementa && !ultimo) begin
            r_endereco <= r_endereco + c_LARGURA'(1);
        end
    end

    assign {trilha, setor} = r_endereco;
    assign ultimo          = &r_endereco;

endmodule

`default_nettype wire

// File: rtl/hd_controlador_dma.sv
// ============================================================================
// Module : hd_controlador_dma
// Two-cycle-per-word block copier between the HD and main memory.
//          Optional macro HD_CHECKSUM_EN adds the soma_verif word checksum.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hd_controlador_dma #(
    parameter int BITS_TRILHA = hd_pkg::BITS_TRILHA,
    parameter int BITS_SETOR  = hd_pkg::BITS_SETOR,
    parameter int BITS_MEM    = 10,
    parameter int BITS_CONT   = 11
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicia,
    input  logic                   direcao,
    input  logic [BITS_TRILHA-1:0] trilha_ini,
    input  logic [BITS_SETOR-1:0]  setor_ini,
    input  logic [BITS_MEM-1:0]    end_mem_ini,
    input  logic [BITS_CONT-1:0]   num_palavras,
    output logic [BITS_TRILHA-1:0] trilha,
    output logic [BITS_SETOR-1:0]  setor,
    output logic                   Sel_HD_Lei_Esc,
    output logic [31:0]            dado_hd_escrita,
    input  logic [31:0]            dado_hd_leitura,
    output logic [BITS_MEM-1:0]    end_mem,
    output logic                   escrita_mem,
    output logic [31:0]            dado_mem_escrita,
    input  logic [31:0]            dado_mem_leitura,
    output logic                   ocupado,
    output logic                   concluido,
    output logic                   erro
`ifdef HD_CHECKSUM_EN
    ,
    output logic [31:0]            soma_verif
`endif
);

    import hd_pkg::*;

    localparam logic [BITS_CONT-1:0] c_CONT_UM = BITS_CONT'(1);

    estado_t              r_estado;
    estado_t              w_prox_estado;
    logic                 r_direcao;
    logic [BITS_CONT-1:0] r_cont;
    logic [BITS_MEM-1:0]  r_end_mem;
    logic                 r_erro;
    logic                 w_aceita;
    logic                 w_escrita;
    logic                 w_ultimo;
    logic [31:0]          w_dado_origem;

    assign w_aceita      = (r_estado == OCIOSO) && inicia;
    assign w_escrita     = (r_estado == ESCRITA);
    assign w_dado_origem = (r_direcao == DIR_HD_PARA_MEM) ? dado_hd_leitura : dado_mem_leitura;

    hd_contador_endereco #(
        .BITS_TRILHA (BITS_TRILHA),
        .BITS_SETOR  (BITS_SETOR)
    ) u_contador (
        .clock        (clock),
        .reset        (reset),
        .carrega      (w_aceita),
        .incrementa   (w_escrita),
        .trilha_carga (trilha_ini),
        .setor_carga  (setor_ini),
        .trilha       (trilha),
        .setor        (setor),
        .ultimo       (w_ultimo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // The last word wins over overflow: a run ending exactly on the last sector is clean.
    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO:  if (inicia) w_prox_estado = (num_palavras == '0) ? FIM : LEITURA;
            LEITURA: w_prox_estado = ESCRITA;
            ESCRITA: w_prox_estado = ((r_cont == c_CONT_UM) || w_ultimo) ? FIM : LEITURA;
            FIM:     w_prox_estado = OCIOSO;
            default: w_prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_direcao <= 1'b0;
            r_cont    <= '0;
            r_end_mem <= '0;
            r_erro    <= 1'b0;
        end else if (w_aceita) begin
            r_direcao <= direcao;
            r_cont    <= num_palavras;
            r_end_mem <= end_mem_ini;
            r_erro    <= 1'b0;
        end else if (w_escrita) begin
            r_cont    <= r_cont - c_CONT_UM;
            r_end_mem <= r_end_mem + BITS_MEM'(1);
            if ((r_cont != c_CONT_UM) && w_ultimo) begin
                r_erro <= 1'b1;
            end
        end
    end

`ifdef HD_CHECKSUM_EN
    logic [31:0] r_soma;

    always_ff @(posedge clock) begin
        if (reset || w_aceita) begin
            r_soma <= '0;
        end else if (w_escrita) begin
            r_soma <= r_soma + w_dado_origem;
        end
    end

    assign soma_verif = r_soma;
`endif

    // Data ports stay at zero outside ESCRITA so the idle bus is quiet.
    always_comb begin
        ocupado          = (r_estado != OCIOSO);
        concluido        = (r_estado == FIM);
        escrita_mem      = w_escrita && (r_direcao == DIR_HD_PARA_MEM);
        Sel_HD_Lei_Esc   = w_escrita && (r_direcao == DIR_MEM_PARA_HD);
        dado_mem_escrita = '0;
        dado_hd_escrita  = '0;
        if (escrita_mem) dado_mem_escrita = w_dado_origem;
        if (Sel_HD_Lei_Esc) dado_hd_escrita = w_dado_origem;
    end

    assign end_mem = r_end_mem;
    assign erro    = r_erro;

endmodule

`default_nettype wire

// File: tb/tb_hd_controlador_dma.sv
// ============================================================================
// Module : tb_hd_controlador_dma
// Directed bench for hd_controlador_dma with an expected-event scoreboard.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hd_controlador_dma;

    localparam int PER = 10;
    localparam int T_MEMW = 0;
    localparam int T_HDW  = 1;
    localparam int T_FIM  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inicia = 1'b0;
    logic        direcao = 1'b0;
    logic [3:0]  trilha_ini = '0;
    logic [5:0]  setor_ini = '0;
    logic [9:0]  end_mem_ini = '0;
    logic [10:0] num_palavras = '0;
    logic [3:0]  trilha;
    logic [5:0]  setor;
    logic        Sel_HD_Lei_Esc;
    logic [31:0] dado_hd_escrita;
    logic [31:0] dado_hd_leitura;
    logic [9:0]  end_mem;
    logic        escrita_mem;
    logic [31:0] dado_mem_escrita;
    logic [31:0] dado_mem_leitura;
    logic        ocupado;
    logic        concluido;
    logic        erro;
`ifdef HD_CHECKSUM_EN
    logic [31:0] soma_verif;
`endif

    hd_controlador_dma dut (
        .clock            (clock),
        .reset            (reset),
        .inicia           (inicia),
        .direcao          (direcao),
        .trilha_ini       (trilha_ini),
        .setor_ini        (setor_ini),
        .end_mem_ini      (end_mem_ini),
        .num_palavras     (num_palavras),
        .trilha           (trilha),
        .setor            (setor),
        .Sel_HD_Lei_Esc   (Sel_HD_Lei_Esc),
        .dado_hd_escrita  (dado_hd_escrita),
        .dado_hd_leitura  (dado_hd_leitura),
        .end_mem          (end_mem),
        .escrita_mem      (escrita_mem),
        .dado_mem_escrita (dado_mem_escrita),
        .dado_mem_leitura (dado_mem_leitura),
        .ocupado          (ocupado),
        .concluido        (concluido),
        .erro             (erro)
`ifdef HD_CHECKSUM_EN
        ,
        .soma_verif       (soma_verif)
`endif
    );

    always #(PER/2) clock = ~clock;

    typedef struct {
        int          tipo;
        int          end_a;
        logic [31:0] dado;
        logic        erro_v;
        time         t;
    } evento_t;

    evento_t     q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_arr [1024];

    function automatic logic [31:0] hd_word(input int t, input int s);
        return 32'hD15C_0000 | 32'(t * 256 + s);
    endfunction

    // Registered reads, 1-cycle latency, like the real HD and memory.
    always @(posedge clock) begin
        dado_hd_leitura  <= hd_word(int'(trilha), int'(setor));
        dado_mem_leitura <= mem_arr[end_mem];
    end

    task automatic verifica(input int tipo, input int end_a, input logic [31:0] dado, input logic erro_v);
        evento_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event tipo=%0d addr=%0h data=%08h at %0t", tipo, end_a, dado, $time);
        end else begin
            e = q.pop_front();
            if (e.tipo != tipo || e.end_a != end_a || (tipo != T_FIM && e.dado != dado)) begin
                errors++;
                $display("FAIL event tipo/addr/data: got %0d/%0h/%08h, expected %0d/%0h/%08h at %0t",
                         tipo, end_a, dado, e.tipo, e.end_a, e.dado, $time);
            end else if (tipo == T_FIM && (e.erro_v != erro_v || e.t != $time)) begin
                errors++;
                $display("FAIL concluido erro/time: got %0b/%0t, expected %0b/%0t",
                         erro_v, $time, e.erro_v, e.t);
            end
`ifdef HD_CHECKSUM_EN
            else if (tipo == T_FIM && soma_verif != e.dado) begin
                errors++;
                $display("FAIL soma_verif: got %08h, expected %08h", soma_verif, e.dado);
            end
`endif
        end
    endtask

    always @(negedge clock) begin
        if (escrita_mem === 1'b1 && Sel_HD_Lei_Esc === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL dual_write_enable: both enables high at %0t", $time);
        end
        if (escrita_mem === 1'b1) verifica(T_MEMW, int'(end_mem), dado_mem_escrita, 1'b0);
        if (Sel_HD_Lei_Esc === 1'b1) verifica(T_HDW, int'({trilha, setor}), dado_hd_escrita, 1'b0);
        if (concluido === 1'b1) verifica(T_FIM, 0, 32'h0, erro);
    end

    task automatic checa(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
        end
    endtask

    task automatic checa_zeros(input string nome);
        logic [31:0] w_soma;
        w_soma = '0;
`ifdef HD_CHECKSUM_EN
        w_soma = soma_verif;
`endif
        checa(nome, 64'({trilha, setor, Sel_HD_Lei_Esc, end_mem, escrita_mem, ocupado, concluido, erro,
                         |dado_hd_escrita, |dado_mem_escrita, |w_soma}), 64'h0);
    endtask

    task automatic transfere(input logic dir, input int tr, input int se, input int mem,
                             input int n, input logic segura);
        int          t = tr;
        int          s = se;
        int          a = mem;
        int          k = 0;
        logic        err = 1'b0;
        logic        visto = 1'b0;
        logic [31:0] soma = '0;
        evento_t     e;
        time         t0;
        for (int i = 0; i < n; i++) begin
            e.tipo   = dir ? T_HDW : T_MEMW;
            e.end_a  = dir ? (t * 64 + s) : a;
            e.dado   = dir ? mem_arr[a] : hd_word(t, s);
            e.erro_v = 1'b0;
            e.t      = 0;
            q.push_back(e);
            soma += e.dado;
            k++;
            if (i != n - 1 && t == 15 && s == 63) begin
                err = 1'b1;
                break;
            end
            a = (a + 1) % 1024;
            s++;
            if (s == 64) begin
                s = 0;
                t++;
            end
        end
        @(negedge clock);
        direcao      = dir;
        trilha_ini   = 4'(tr);
        setor_ini    = 6'(se);
        end_mem_ini  = 10'(mem);
        num_palavras = 11'(n);
        inicia       = 1'b1;
        @(posedge clock);
        t0 = $time;
        // Sampled at edge t0, concluido is seen at the negedge after edge t0+2k.
        e.tipo   = T_FIM;
        e.end_a  = 0;
        e.dado   = soma;
        e.erro_v = err;
        e.t      = t0 + 2 * k * PER + PER / 2;
        q.push_back(e);
        #1;
        if (segura) begin
            direcao      = ~dir;
            trilha_ini   = 4'd7;
            setor_ini    = 6'd1;
            end_mem_ini  = 10'h2AA;
            num_palavras = 11'd9;
        end else begin
            inicia = 1'b0;
        end
        for (int c = 0; c < 2 * n + 10; c++) begin
            @(negedge clock);
            if (concluido === 1'b1) begin
                visto = 1'b1;
                break;
            end
        end
        checks++;
        if (!visto) begin
            errors++;
            $display("FAIL concluido_timeout: got none, expected pulse after %0d words", k);
        end
        inicia = 1'b0;
        @(posedge clock);
        #1;
        checa("ocupado_after_fim", 64'(ocupado), 64'h0);
        checa("scoreboard_drained", 64'(q.size()), 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hCAFE_0000 | 32'(i);
        mem_arr[10'h100] = 32'h0000_0001;
        mem_arr[10'h101] = 32'h0000_0002;
        mem_arr[10'h102] = 32'hFFFF_FFFF;

        repeat (3) @(posedge clock);
        #1;
        checa_zeros("reset_outputs");
        reset = 1'b0;

        transfere(1'b0, 2, 5, 'h10, 3, 1'b0);
        checa("erro_after_normal", 64'(erro), 64'h0);
        transfere(1'b1, 3, 62, 'h40, 4, 1'b0);
        transfere(1'b0, 1, 1, 'h50, 0, 1'b0);
        transfere(1'b0, 15, 62, 'h60, 5, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        checa("erro_sticky", 64'(erro), 64'h1);
        transfere(1'b0, 0, 0, 'h70, 0, 1'b0);
        checa("erro_cleared", 64'(erro), 64'h0);
        transfere(1'b0, 5, 0, 'h3FE, 3, 1'b0);
        transfere(1'b1, 6, 10, 'h100, 3, 1'b1);
`ifdef HD_CHECKSUM_EN
        checa("soma_wrap", 64'(soma_verif), 64'h2);
`endif

        // Reset during the second ESCRITA of an 8-word run: exactly two writes survive.
        begin
            evento_t e;
            e.tipo = T_MEMW; e.erro_v = 1'b0; e.t = 0;
            e.end_a = 'h20; e.dado = hd_word(1, 0); q.push_back(e);
            e.end_a = 'h21; e.dado = hd_word(1, 1); q.push_back(e);
        end
        @(negedge clock);
        direcao = 1'b0; trilha_ini = 4'd1; setor_ini = 6'd0; end_mem_ini = 10'h20;
        num_palavras = 11'd8; inicia = 1'b1;
        @(posedge clock);
        #1;
        inicia = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checa("second_escrita_we", 64'(escrita_mem), 64'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checa_zeros("abort_outputs");
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        checa("abort_no_more_events", 64'(q.size()), 64'h0);
        checa("abort_idle", 64'(ocupado), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
